// File: rtl/race_pkg.sv
// Shared types and helpers for the two-player dice-race turn controller.
// The colour encoding matches the upstream colour detector.
package race_pkg;

    localparam int POS_W = 5;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        RED   = 2'b01,
        GREEN = 2'b10,
        BLUE  = 2'b11
    } color_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        MOVE  = 3'd2,
        CHECK = 3'd3,
        WIN   = 3'd4
    } turn_state_t;

    // Dice value carried by each detected colour.
    function automatic logic [1:0] color_to_steps(input color_t c);
        case (c)
            RED:     color_to_steps = 2'd1;
            GREEN:   color_to_steps = 2'd2;
            BLUE:    color_to_steps = 2'd3;
            default: color_to_steps = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/race_turn_controller_if.sv
// Handshake bundle between the colour result manager / button logic (master)
// and the turn controller (slave), including the display-side outputs.
interface race_turn_controller_if;
    import race_pkg::*;

    logic [1:0]       stable_color;
    logic             result_ready;
    logic             roll_req;
    logic             game_restart;
    logic [POS_W-1:0] pos_p0;
    logic [POS_W-1:0] pos_p1;
    logic             cur_player;
    logic [1:0]       steps_left;
    logic             move_step;
    logic [2:0]       turn_state;
    logic             winner_valid;
    logic             winner_id;
    logic             arm_timeout;

    modport master (
        output stable_color, result_ready, roll_req, game_restart,
        input  pos_p0, pos_p1, cur_player, steps_left, move_step,
               turn_state, winner_valid, winner_id, arm_timeout
    );

    modport slave (
        input  stable_color, result_ready, roll_req, game_restart,
        output pos_p0, pos_p1, cur_player, steps_left, move_step,
               turn_state, winner_valid, winner_id, arm_timeout
    );

endinterface

// File: rtl/race_step_timer.sv
// Step-period timer: pulses tick on the last of every STEP_TICKS enabled
// cycles. clear forces the count back to zero so a new move always starts
// a full period.
module race_step_timer #(
    parameter int STEP_TICKS = 12_500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(STEP_TICKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == LAST);

    // Count enabled cycles, wrapping on the terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/race_turn_controller.sv
// Two-player dice-race turn controller. Arms colour detection on a roll
// request, accepts a colour after consecutive matching results, walks the
// current player's token one square per step period, then declares a winner
// or hands the turn over.
// Optional feature: define RACE_ARM_TIMEOUT_EN to abandon an ARM phase after
// ARM_TIMEOUT_TICKS cycles without an accepted colour (pulses arm_timeout).
module race_turn_controller
    import race_pkg::*;
#(
    parameter int TRACK_LEN        = 16,
    parameter int STEP_TICKS       = 12_500_000,
    parameter int REQUIRED_MATCHES = 2
`ifdef RACE_ARM_TIMEOUT_EN
    ,
    parameter int ARM_TIMEOUT_TICKS = 250_000_000
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    race_turn_controller_if.slave bus
);

    localparam logic [POS_W-1:0] FINISH = POS_W'(TRACK_LEN);

    turn_state_t      state;
    color_t           last_color;
    color_t           in_color;
    logic [1:0]       match_cnt;
    logic [1:0]       next_cnt;
    logic [1:0]       steps_left;
    logic [POS_W-1:0] pos_p0;
    logic [POS_W-1:0] pos_p1;
    logic [POS_W-1:0] cur_pos;
    logic [POS_W-1:0] next_pos;
    logic             cur_player;
    logic             move_step;
    logic             winner_valid;
    logic             winner_id;
    logic             accept;
    logic             at_finish;
    logic             tick;
    logic             timer_clear;
    logic             timer_enable;

    assign in_color  = color_t'(bus.stable_color);
    assign cur_pos   = cur_player ? pos_p1 : pos_p0;
    assign next_pos  = cur_pos + POS_W'(1);
    assign at_finish = (cur_pos == FINISH);

    // Timer only runs in MOVE; any other state (or a restart) rewinds it so
    // the first advance lands a full step period after MOVE entry.
    assign timer_enable = (state == MOVE);
    assign timer_clear  = bus.game_restart || (state != MOVE);

    race_step_timer #(
        .STEP_TICKS(STEP_TICKS)
    ) u_step_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (timer_clear),
        .enable (timer_enable),
        .tick   (tick)
    );

    // Match-counter update and acceptance decision for the current result.
    always_comb begin
        next_cnt = match_cnt;
        accept   = 1'b0;
        if ((state == ARM) && bus.result_ready) begin
            if (in_color == NONE) begin
                next_cnt = 2'd0;
            end else if (in_color == last_color) begin
                next_cnt = (match_cnt == 2'd3) ? 2'd3 : match_cnt + 2'd1;
            end else begin
                next_cnt = 2'd1;
            end
            accept = (in_color != NONE) && (next_cnt >= 2'(REQUIRED_MATCHES));
        end
    end

`ifdef RACE_ARM_TIMEOUT_EN
    logic [31:0] arm_cnt;
    logic        timeout_hit;
    logic        arm_timeout;

    // Acceptance on the terminal cycle takes precedence over the timeout.
    assign timeout_hit = (state == ARM) && !accept &&
                         (arm_cnt == 32'(ARM_TIMEOUT_TICKS - 1));

    // Cycles spent in the current ARM phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
        end else if (bus.game_restart || (state != ARM) || timeout_hit) begin
            arm_cnt <= '0;
        end else begin
            arm_cnt <= arm_cnt + 32'd1;
        end
    end

    assign bus.arm_timeout = arm_timeout;
`else
    assign bus.arm_timeout = 1'b0;
`endif

    // Turn FSM with registered outputs; game_restart mirrors reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_color   <= NONE;
            match_cnt    <= 2'd0;
            steps_left   <= 2'd0;
            pos_p0       <= '0;
            pos_p1       <= '0;
            cur_player   <= 1'b0;
            move_step    <= 1'b0;
            winner_valid <= 1'b0;
            winner_id    <= 1'b0;
`ifdef RACE_ARM_TIMEOUT_EN
            arm_timeout  <= 1'b0;
`endif
        end else if (bus.game_restart) begin
            state        <= IDLE;
            last_color   <= NONE;
            match_cnt    <= 2'd0;
            steps_left   <= 2'd0;
            pos_p0       <= '0;
            pos_p1       <= '0;
            cur_player   <= 1'b0;
            move_step    <= 1'b0;
            winner_valid <= 1'b0;
            winner_id    <= 1'b0;
`ifdef RACE_ARM_TIMEOUT_EN
            arm_timeout  <= 1'b0;
`endif
        end else begin
            move_step <= 1'b0;
`ifdef RACE_ARM_TIMEOUT_EN
            arm_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.roll_req) begin
                        state     <= ARM;
                        match_cnt <= 2'd0;
                    end
                end
                ARM: begin
                    if (bus.result_ready) begin
                        match_cnt <= next_cnt;
                        if (in_color != NONE) begin
                            last_color <= in_color;
                        end
                    end
                    if (accept) begin
                        steps_left <= color_to_steps(in_color);
                        state      <= MOVE;
                    end
`ifdef RACE_ARM_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state       <= IDLE;
                        match_cnt   <= 2'd0;
                        arm_timeout <= 1'b1;
                    end
`endif
                end
                MOVE: begin
                    if ((steps_left == 2'd0) || at_finish) begin
                        state <= CHECK;
                    end else if (tick) begin
                        if (cur_player) begin
                            pos_p1 <= next_pos;
                        end else begin
                            pos_p0 <= next_pos;
                        end
                        // Landing on the finish discards any remaining steps.
                        steps_left <= (next_pos == FINISH) ? 2'd0 : steps_left - 2'd1;
                        move_step  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (at_finish) begin
                        state        <= WIN;
                        winner_valid <= 1'b1;
                        winner_id    <= cur_player;
                    end else begin
                        cur_player <= ~cur_player;
                        state      <= IDLE;
                    end
                end
                WIN: begin
                    state <= WIN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pos_p0       = pos_p0;
    assign bus.pos_p1       = pos_p1;
    assign bus.cur_player   = cur_player;
    assign bus.steps_left   = steps_left;
    assign bus.move_step    = move_step;
    assign bus.turn_state   = state;
    assign bus.winner_valid = winner_valid;
    assign bus.winner_id    = winner_id;

endmodule

// File: tb/tb_race_turn_controller.sv
// Directed bench for race_turn_controller (TRACK_LEN=8, STEP_TICKS=4,
// REQUIRED_MATCHES=2, ARM_TIMEOUT_TICKS=50). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_race_turn_controller;

    localparam int TRACK_LEN         = 8;
    localparam int STEP_TICKS        = 4;
    localparam int REQUIRED_MATCHES  = 2;
    localparam int ARM_TIMEOUT_TICKS = 50;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_RED   = 2'd1;
    localparam logic [1:0] C_GREEN = 2'd2;
    localparam logic [1:0] C_BLUE  = 2'd3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    race_turn_controller_if bus();

    race_turn_controller #(
        .TRACK_LEN        (TRACK_LEN),
        .STEP_TICKS       (STEP_TICKS),
        .REQUIRED_MATCHES (REQUIRED_MATCHES)
`ifdef RACE_ARM_TIMEOUT_EN
        ,
        .ARM_TIMEOUT_TICKS(ARM_TIMEOUT_TICKS)
`endif
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"},        32'(bus.turn_state),   32'(S_IDLE));
        check({tag, "_pos_p0"},       32'(bus.pos_p0),       0);
        check({tag, "_pos_p1"},       32'(bus.pos_p1),       0);
        check({tag, "_cur_player"},   32'(bus.cur_player),   0);
        check({tag, "_steps_left"},   32'(bus.steps_left),   0);
        check({tag, "_move_step"},    32'(bus.move_step),    0);
        check({tag, "_winner_valid"}, 32'(bus.winner_valid), 0);
        check({tag, "_winner_id"},    32'(bus.winner_id),    0);
        check({tag, "_arm_timeout"},  32'(bus.arm_timeout),  0);
    endtask

    task automatic roll();
        bus.roll_req = 1'b1;
        @(negedge clk);
        bus.roll_req = 1'b0;
    endtask

    task automatic send(input logic [1:0] c);
        bus.stable_color = c;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        bus.stable_color = C_NONE;
    endtask

    task automatic restart();
        bus.game_restart = 1'b1;
        @(negedge clk);
        bus.game_restart = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
        int n = 0;
        while (bus.turn_state !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.turn_state), 32'(target));
    endtask

    task automatic turn(input logic [1:0] c);
        roll();
        send(c);
        send(c);
        wait_state("turn_done", S_IDLE, 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.stable_color = C_NONE;
        bus.result_ready = 1'b0;
        bus.roll_req     = 1'b0;
        bus.game_restart = 1'b0;
        reset_n          = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Player 0 rolls GREEN: two steps, advances at +4 and +8 cycles.
        roll();
        check("t1_arm", 32'(bus.turn_state), 32'(S_ARM));
        send(C_GREEN);
        check("t1_arm_one_match", 32'(bus.turn_state), 32'(S_ARM));
        send(C_GREEN);
        check("t1_move", 32'(bus.turn_state), 32'(S_MOVE));
        check("t1_steps", 32'(bus.steps_left), 2);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t1_move_step", 32'(bus.move_step), 32'((i == 4) || (i == 8)));
            if (i == 4) begin
                check("t1_pos_mid", 32'(bus.pos_p0), 1);
                check("t1_steps_mid", 32'(bus.steps_left), 1);
            end
        end
        check("t1_pos_end", 32'(bus.pos_p0), 2);
        check("t1_steps_end", 32'(bus.steps_left), 0);
        @(negedge clk);
        check("t1_check", 32'(bus.turn_state), 32'(S_CHECK));
        @(negedge clk);
        check("t1_idle", 32'(bus.turn_state), 32'(S_IDLE));
        check("t1_cur_player", 32'(bus.cur_player), 1);

        // Player 1: RED, BLUE, NONE, BLUE leave ARM; one more BLUE accepts.
        roll();
        send(C_RED);
        send(C_BLUE);
        send(C_NONE);
        check("t2_arm_after_none", 32'(bus.turn_state), 32'(S_ARM));
        check("t2_steps_zero", 32'(bus.steps_left), 0);
        send(C_BLUE);
        check("t2_arm_after_blue", 32'(bus.turn_state), 32'(S_ARM));
        send(C_BLUE);
        check("t2_move", 32'(bus.turn_state), 32'(S_MOVE));
        check("t2_steps", 32'(bus.steps_left), 3);
        wait_state("t2_idle", S_IDLE, 40);
        check("t2_pos_p1", 32'(bus.pos_p1), 3);
        check("t2_pos_p0", 32'(bus.pos_p0), 2);
        check("t2_cur_player", 32'(bus.cur_player), 0);

        // Set up player 1 on square 6.
        turn(C_RED);
        check("setup_pos_p0", 32'(bus.pos_p0), 3);
        turn(C_BLUE);
        check("setup_pos_p1", 32'(bus.pos_p1), 6);
        check("setup_cur_player", 32'(bus.cur_player), 0);

        // Ignored inputs: roll_req during MOVE, result_ready during IDLE.
        roll();
        send(C_RED);
        send(C_RED);
        check("t4_move", 32'(bus.turn_state), 32'(S_MOVE));
        roll();
        check("t4_roll_in_move_state", 32'(bus.turn_state), 32'(S_MOVE));
        check("t4_roll_in_move_steps", 32'(bus.steps_left), 1);
        check("t4_roll_in_move_pos", 32'(bus.pos_p0), 3);
        wait_state("t4_idle", S_IDLE, 40);
        check("t4_pos_p0", 32'(bus.pos_p0), 4);
        check("t4_cur_player", 32'(bus.cur_player), 1);
        send(C_BLUE);
        check("t4_result_in_idle_state", 32'(bus.turn_state), 32'(S_IDLE));
        check("t4_result_in_idle_steps", 32'(bus.steps_left), 0);
        check("t4_result_in_idle_pos_p1", 32'(bus.pos_p1), 6);

        // Player 1 from 6 rolls BLUE: reaches 8 after two steps and wins.
        roll();
        send(C_BLUE);
        check("t3_arm", 32'(bus.turn_state), 32'(S_ARM));
        send(C_BLUE);
        check("t3_move", 32'(bus.turn_state), 32'(S_MOVE));
        check("t3_steps", 32'(bus.steps_left), 3);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check("t3_pos_mid", 32'(bus.pos_p1), 7);
                check("t3_steps_mid", 32'(bus.steps_left), 2);
            end
        end
        check("t3_pos_end", 32'(bus.pos_p1), 8);
        check("t3_steps_forced", 32'(bus.steps_left), 0);
        check("t3_move_step_end", 32'(bus.move_step), 1);
        @(negedge clk);
        check("t3_check", 32'(bus.turn_state), 32'(S_CHECK));
        check("t3_winner_not_yet", 32'(bus.winner_valid), 0);
        @(negedge clk);
        check("t3_win", 32'(bus.turn_state), 32'(S_WIN));
        check("t3_winner_valid", 32'(bus.winner_valid), 1);
        check("t3_winner_id", 32'(bus.winner_id), 1);
        check("t3_cur_player_kept", 32'(bus.cur_player), 1);
        roll();
        check("t3_roll_in_win", 32'(bus.turn_state), 32'(S_WIN));
        send(C_BLUE);
        check("t3_result_in_win", 32'(bus.turn_state), 32'(S_WIN));
        check("t3_pos_hold", 32'(bus.pos_p1), 8);

        // Restart from WIN, then restart mid-tick in MOVE.
        restart();
        check_reset_state("restart_win");
        roll();
        send(C_GREEN);
        send(C_GREEN);
        check("t5_move", 32'(bus.turn_state), 32'(S_MOVE));
        repeat (2) @(negedge clk);
        restart();
        check_reset_state("restart_move");
        repeat (6) @(negedge clk);
        check("t5_no_late_step", 32'(bus.pos_p0), 0);
        check("t5_still_idle", 32'(bus.turn_state), 32'(S_IDLE));

        // Asynchronous reset in the middle of a move.
        roll();
        send(C_GREEN);
        send(C_GREEN);
        repeat (5) @(negedge clk);
        check("t5_pos_before_reset", 32'(bus.pos_p0), 1);
        check("t5_steps_before_reset", 32'(bus.steps_left), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef RACE_ARM_TIMEOUT_EN
        // ARM abandoned after 50 cycles without an accepted colour.
        roll();
        repeat (ARM_TIMEOUT_TICKS - 1) @(negedge clk);
        check("t6_arm_before_timeout", 32'(bus.turn_state), 32'(S_ARM));
        check("t6_no_pulse_yet", 32'(bus.arm_timeout), 0);
        @(negedge clk);
        check("t6_pulse", 32'(bus.arm_timeout), 1);
        check("t6_idle", 32'(bus.turn_state), 32'(S_IDLE));
        check("t6_cur_player", 32'(bus.cur_player), 0);
        @(negedge clk);
        check("t6_pulse_one_cycle", 32'(bus.arm_timeout), 0);
`else
        // Without the timeout, ARM waits indefinitely.
        roll();
        repeat (200) @(negedge clk);
        check("t6_arm_held", 32'(bus.turn_state), 32'(S_ARM));
        check("t6_no_timeout", 32'(bus.arm_timeout), 0);
        restart();
        check("t6_restart_from_arm", 32'(bus.turn_state), 32'(S_IDLE));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
